// File: rtl/cpu_ctrl_if.sv
// Control/bus bundle between the cpu_ctrl sequencer and the cpu_data
// datapath plus program/data memories.
interface cpu_ctrl_if #(
  parameter int WIDTH          = 8,
  parameter int IWIDTH         = 5,
  parameter int PC_WIDTH       = 8,
  parameter int REG_F_SEL_SIZE = 4,
  parameter int IN_B_SEL_SIZE  = 2
);
  logic                      START;
  logic [PC_WIDTH-1:0]       PM_ADDR;
  logic [IWIDTH+WIDTH-1:0]   PM_DATA;
  logic                      Z;
  logic [REG_F_SEL_SIZE-1:0] REG_F_SEL;
  logic                      EN_REG_F;
  logic [WIDTH-1:0]          D_MEM_ADDR;
  logic                      D_MEM_ADDR_MODE;
  logic                      EN_D_MEM;
  logic [IN_B_SEL_SIZE-1:0]  IN_B_SEL;
  logic [WIDTH-1:0]          IMM;
  logic [IWIDTH-2:0]         ALU_OUT;
  logic                      EN_ACC;
  logic                      HALTED;
  logic                      ERR;

  // sequencer side
  modport master (
    input  START, PM_DATA, Z,
    output PM_ADDR, REG_F_SEL, EN_REG_F, D_MEM_ADDR, D_MEM_ADDR_MODE,
           EN_D_MEM, IN_B_SEL, IMM, ALU_OUT, EN_ACC, HALTED, ERR
  );

  // datapath / memory / run-control side
  modport slave (
    output START, PM_DATA, Z,
    input  PM_ADDR, REG_F_SEL, EN_REG_F, D_MEM_ADDR, D_MEM_ADDR_MODE,
           EN_D_MEM, IN_B_SEL, IMM, ALU_OUT, EN_ACC, HALTED, ERR
  );
endinterface

// File: rtl/cpu_ctrl.sv
// Single-cycle instruction sequencer: PC, fetch from async program memory,
// decode to datapath controls, branches on Z, CALL/RET return stack and
// HALT/START run control.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_BOOT | one idle cycle after reset; PC held at 0, no enables
// S_RUN  | fetch/decode/execute one instruction per cycle
// S_HALT | stopped after a HALT instruction; PC held, waits for START
module cpu_ctrl #(
  parameter int WIDTH          = 8,
  parameter int IWIDTH         = 5,
  parameter int PC_WIDTH       = 8,
  parameter int REG_F_SEL_SIZE = 4,
  parameter int IN_B_SEL_SIZE  = 2,
  parameter int STACK_DEPTH    = 4
) (
  input  logic      CLK,
  input  logic      RST_N,
  cpu_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;

  localparam int SI_W = $clog2(STACK_DEPTH);
  localparam int SP_W = SI_W + 1;

  localparam logic [SP_W-1:0]     SP_FULL = SP_W'(STACK_DEPTH);
  localparam logic [SP_W-1:0]     SP_ONE  = SP_W'(1);
  localparam logic [SI_W-1:0]     SI_ONE  = SI_W'(1);
  localparam logic [PC_WIDTH-1:0] PC_ONE  = PC_WIDTH'(1);

  localparam logic [IWIDTH-1:0] OP_LDI  = IWIDTH'(1);
  localparam logic [IWIDTH-1:0] OP_LD   = IWIDTH'(2);
  localparam logic [IWIDTH-1:0] OP_LDR  = IWIDTH'(3);
  localparam logic [IWIDTH-1:0] OP_ST   = IWIDTH'(4);
  localparam logic [IWIDTH-1:0] OP_STI  = IWIDTH'(5);
  localparam logic [IWIDTH-1:0] OP_STR  = IWIDTH'(6);
  localparam logic [IWIDTH-1:0] OP_JMP  = IWIDTH'(7);
  localparam logic [IWIDTH-1:0] OP_JZ   = IWIDTH'(8);
  localparam logic [IWIDTH-1:0] OP_JNZ  = IWIDTH'(9);
  localparam logic [IWIDTH-1:0] OP_CALL = IWIDTH'(10);
  localparam logic [IWIDTH-1:0] OP_RET  = IWIDTH'(11);
  localparam logic [IWIDTH-1:0] OP_HALT = IWIDTH'(12);
  localparam logic [IWIDTH-1:0] OP_RSV0 = IWIDTH'(13);
  localparam logic [IWIDTH-1:0] OP_RSV1 = IWIDTH'(14);
  localparam logic [IWIDTH-1:0] OP_RSV2 = IWIDTH'(15);

  localparam logic [IN_B_SEL_SIZE-1:0] B_IMM = IN_B_SEL_SIZE'(0);
  localparam logic [IN_B_SEL_SIZE-1:0] B_REG = IN_B_SEL_SIZE'(1);
  localparam logic [IN_B_SEL_SIZE-1:0] B_MEM = IN_B_SEL_SIZE'(2);
  localparam logic [IWIDTH-2:0]        ALU_PASS_B = '1;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [SP_W-1:0]     sp_q, sp_d;
  logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];
  logic [PC_WIDTH-1:0] stack_d [STACK_DEPTH];
  logic                err_q, err_d;

  logic [IWIDTH-1:0]   opcode;
  logic [WIDTH-1:0]    operand;
  logic                is_alu;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] op_pc;
  logic [SI_W-1:0]     push_idx;
  logic [SI_W-1:0]     pop_idx;

  assign opcode   = bus.PM_DATA[IWIDTH+WIDTH-1:WIDTH];
  assign operand  = bus.PM_DATA[WIDTH-1:0];
  assign is_alu   = opcode[IWIDTH-1];
  assign pc_inc   = pc_q + PC_ONE;
  assign op_pc    = PC_WIDTH'(operand);
  assign push_idx = sp_q[SI_W-1:0];
  // SP is nonzero whenever pop_idx is used, so the low bits minus one
  // always land on the top entry (SP=DEPTH wraps the low bits to 0 first).
  assign pop_idx  = sp_q[SI_W-1:0] - SI_ONE;

  // State, PC, return stack and sticky error registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_BOOT;
      pc_q    <= '0;
      sp_q    <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= stack_d[i];
    end
  end

  // Next state: run control, PC sequencing, stack push/pop, error capture
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    err_d   = err_q;
    for (int i = 0; i < STACK_DEPTH; i++) stack_d[i] = stack_q[i];

    case (state_q)
      S_BOOT: state_d = S_RUN;
      S_HALT: if (bus.START) state_d = S_RUN;
      S_RUN: begin
        pc_d = pc_inc;
        if (!is_alu) begin
          case (opcode)
            OP_JMP: pc_d = op_pc;
            OP_JZ:  if (bus.Z)  pc_d = op_pc;
            OP_JNZ: if (!bus.Z) pc_d = op_pc;
            OP_CALL: begin
              // a full stack makes CALL a no-op that just flags the error
              if (sp_q == SP_FULL) begin
                err_d = 1'b1;
              end else begin
                stack_d[push_idx] = pc_inc;
                sp_d              = sp_q + SP_ONE;
                pc_d              = op_pc;
              end
            end
            OP_RET: begin
              if (sp_q == '0) begin
                err_d = 1'b1;
              end else begin
                sp_d = sp_q - SP_ONE;
                pc_d = stack_q[pop_idx];
              end
            end
            OP_HALT: state_d = S_HALT;
            OP_RSV0, OP_RSV1, OP_RSV2: err_d = 1'b1;
            default: ;
          endcase
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  // Output decode: datapath controls only while running, defaults otherwise
  always_comb begin
    bus.PM_ADDR         = pc_q;
    bus.HALTED          = (state_q == S_HALT);
    bus.ERR             = err_q;
    bus.REG_F_SEL       = '0;
    bus.EN_REG_F        = 1'b0;
    bus.D_MEM_ADDR      = '0;
    bus.D_MEM_ADDR_MODE = 1'b0;
    bus.EN_D_MEM        = 1'b0;
    bus.IN_B_SEL        = B_IMM;
    bus.IMM             = '0;
    bus.ALU_OUT         = ALU_PASS_B;
    bus.EN_ACC          = 1'b0;

    if (state_q == S_RUN) begin
      if (is_alu) begin
        bus.ALU_OUT    = opcode[IWIDTH-2:0];
        bus.IN_B_SEL   = B_MEM;
        bus.D_MEM_ADDR = operand;
        bus.EN_ACC     = 1'b1;
      end else begin
        case (opcode)
          OP_LDI: begin
            bus.IMM    = operand;
            bus.EN_ACC = 1'b1;
          end
          OP_LD: begin
            bus.D_MEM_ADDR = operand;
            bus.IN_B_SEL   = B_MEM;
            bus.EN_ACC     = 1'b1;
          end
          OP_LDR: begin
            bus.REG_F_SEL = operand[REG_F_SEL_SIZE-1:0];
            bus.IN_B_SEL  = B_REG;
            bus.EN_ACC    = 1'b1;
          end
          OP_ST: begin
            bus.D_MEM_ADDR = operand;
            bus.EN_D_MEM   = 1'b1;
          end
          OP_STI: begin
            bus.REG_F_SEL       = operand[REG_F_SEL_SIZE-1:0];
            bus.D_MEM_ADDR_MODE = 1'b1;
            bus.EN_D_MEM        = 1'b1;
          end
          OP_STR: begin
            bus.REG_F_SEL = operand[REG_F_SEL_SIZE-1:0];
            bus.EN_REG_F  = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Bench for cpu_ctrl: directed program phases plus a random program run,
// all checked every cycle against an instruction-level reference model.
`timescale 1ns/100ps
module tb_cpu_ctrl;
  localparam int WIDTH = 8, IWIDTH = 5, PC_WIDTH = 8;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  cpu_ctrl_if #(.WIDTH(WIDTH), .IWIDTH(IWIDTH), .PC_WIDTH(PC_WIDTH),
                .REG_F_SEL_SIZE(4), .IN_B_SEL_SIZE(2)) bus ();

  cpu_ctrl #(.WIDTH(WIDTH), .IWIDTH(IWIDTH), .PC_WIDTH(PC_WIDTH),
             .REG_F_SEL_SIZE(4), .IN_B_SEL_SIZE(2), .STACK_DEPTH(4))
    dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));

  logic [12:0] pm [256];
  assign bus.PM_DATA = pm[bus.PM_ADDR];

  localparam int NOP = 0, LDI = 1, LD = 2, LDR = 3, ST = 4, STI = 5, STR = 6;
  localparam int JMP = 7, JZ = 8, JNZ = 9, CALL = 10, RET = 11, HLT = 12;
  localparam int ADD = 21;

  int n_cmp = 0;
  int n_err = 0;

  // reference model: architectural state only
  int m_pc;
  int m_stack[$];
  bit m_boot, m_halt, m_err;

  function automatic logic [12:0] ins(int opc, int op);
    return 13'((opc << 8) | (op & 255));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [29:0] expected_ctl();
    int en_rf = 0, en_dm = 0, en_acc = 0, b = 0, alu = 15, mode = 0;
    int rsel = 0, dma = 0, imm = 0, opc, op;
    if (RST_N && !m_boot && !m_halt) begin
      opc = int'(pm[m_pc][12:8]);
      op  = int'(pm[m_pc][7:0]);
      if (opc >= 16) begin
        alu = opc - 16; b = 2; dma = op; en_acc = 1;
      end else begin
        case (opc)
          LDI: begin imm = op; en_acc = 1; end
          LD:  begin dma = op; b = 2; en_acc = 1; end
          LDR: begin rsel = op % 16; b = 1; en_acc = 1; end
          ST:  begin dma = op; en_dm = 1; end
          STI: begin rsel = op % 16; mode = 1; en_dm = 1; end
          STR: begin rsel = op % 16; en_rf = 1; end
          default: ;
        endcase
      end
    end
    return {1'(en_rf), 1'(en_dm), 1'(en_acc), 2'(b), 4'(alu), 1'(mode),
            4'(rsel), 8'(dma), 8'(imm)};
  endfunction

  task automatic check_all();
    chk("ctl", {bus.EN_REG_F, bus.EN_D_MEM, bus.EN_ACC, bus.IN_B_SEL, bus.ALU_OUT,
                bus.D_MEM_ADDR_MODE, bus.REG_F_SEL, bus.D_MEM_ADDR, bus.IMM},
        expected_ctl());
    chk("pm_addr", bus.PM_ADDR, m_pc);
    chk("halted", bus.HALTED, m_halt);
    chk("err", bus.ERR, m_err);
  endtask

  task automatic model_reset();
    m_pc = 0; m_stack.delete(); m_boot = 1; m_halt = 0; m_err = 0;
  endtask

  task automatic advance(input bit z, input bit st);
    int opc, op, nxt;
    if (m_boot) begin
      m_boot = 0;
    end else if (m_halt) begin
      if (st) m_halt = 0;
    end else begin
      opc = int'(pm[m_pc][12:8]);
      op  = int'(pm[m_pc][7:0]);
      nxt = (m_pc + 1) % 256;
      case (opc)
        JMP:  nxt = op;
        JZ:   if (z)  nxt = op;
        JNZ:  if (!z) nxt = op;
        CALL: if (m_stack.size() == 4) m_err = 1;
              else begin m_stack.push_back(nxt); nxt = op; end
        RET:  if (m_stack.size() == 0) m_err = 1;
              else nxt = m_stack.pop_back();
        HLT:  m_halt = 1;
        13, 14, 15: m_err = 1;
        default: ;
      endcase
      m_pc = nxt;
    end
  endtask

  // one clock: check at the falling edge, model follows the rising edge
  task automatic step(input bit z, input bit st);
    bus.Z = z; bus.START = st;
    @(negedge CLK);
    check_all();
    @(posedge CLK);
    advance(z, st);
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    model_reset();
    @(negedge CLK);
    check_all();
    @(posedge CLK);
    #1 RST_N = 1'b1;
  endtask

  task automatic clear_pm();
    for (int i = 0; i < 256; i++) pm[i] = ins(NOP, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.Z = 1'b0; bus.START = 1'b0;
    model_reset();

    // fetch/decode and branches
    clear_pm();
    pm[8'h00] = ins(LDI, 8'h69);
    pm[8'h01] = ins(ST, 8'h00);
    pm[8'h02] = ins(STR, 3);
    pm[8'h03] = ins(ADD, 8'h00);
    pm[8'h04] = ins(JZ, 8'h40);
    pm[8'h40] = ins(JZ, 8'h50);
    pm[8'h41] = ins(JNZ, 8'h60);
    pm[8'h60] = ins(JNZ, 8'h70);
    pm[8'h61] = ins(JMP, 8'hFF);
    do_reset();
    chk("boot_pm_addr", bus.PM_ADDR, 0);
    chk("boot_en_acc", bus.EN_ACC, 0);
    step(0, 1);
    chk("ldi_pm_addr", bus.PM_ADDR, 0);
    chk("ldi_en_acc", bus.EN_ACC, 1);
    chk("ldi_imm", bus.IMM, 8'h69);
    chk("ldi_in_b", bus.IN_B_SEL, 0);
    chk("ldi_alu", bus.ALU_OUT, 4'hF);
    step(0, 1);
    chk("st_pm_addr", bus.PM_ADDR, 1);
    chk("st_en", bus.EN_D_MEM, 1);
    chk("st_mode", bus.D_MEM_ADDR_MODE, 0);
    step(0, 0);
    chk("str_en", bus.EN_REG_F, 1);
    chk("str_sel", bus.REG_F_SEL, 3);
    step(0, 0);
    chk("add_alu", bus.ALU_OUT, 5);
    chk("add_in_b", bus.IN_B_SEL, 2);
    chk("add_en_acc", bus.EN_ACC, 1);
    step(0, 0);
    step(1, 0);
    chk("jz_taken", bus.PM_ADDR, 8'h40);
    step(0, 0);
    chk("jz_not_taken", bus.PM_ADDR, 8'h41);
    step(0, 0);
    chk("jnz_taken", bus.PM_ADDR, 8'h60);
    step(1, 0);
    chk("jnz_not_taken", bus.PM_ADDR, 8'h61);
    step(0, 0);
    chk("jmp_ff", bus.PM_ADDR, 8'hFF);
    step(0, 0);
    chk("pc_wrap", bus.PM_ADDR, 8'h00);

    // return stack overflow / underflow
    clear_pm();
    pm[8'h00] = ins(CALL, 8'h20);
    pm[8'h20] = ins(CALL, 8'h30);
    pm[8'h30] = ins(CALL, 8'h40);
    pm[8'h40] = ins(CALL, 8'h50);
    pm[8'h50] = ins(CALL, 8'h60);
    pm[8'h51] = ins(RET, 0);
    pm[8'h41] = ins(RET, 0);
    pm[8'h31] = ins(RET, 0);
    pm[8'h21] = ins(RET, 0);
    pm[8'h01] = ins(RET, 0);
    pm[8'h02] = ins(LDI, 8'h55);
    do_reset();
    step(0, 0);
    step(0, 0); chk("call1", bus.PM_ADDR, 8'h20);
    step(0, 0); chk("call2", bus.PM_ADDR, 8'h30);
    step(0, 0); chk("call3", bus.PM_ADDR, 8'h40);
    step(0, 0); chk("call4", bus.PM_ADDR, 8'h50);
    chk("err_before_full", bus.ERR, 0);
    step(0, 0); chk("call_full_pc", bus.PM_ADDR, 8'h51);
    chk("call_full_err", bus.ERR, 1);
    step(0, 0); chk("ret1", bus.PM_ADDR, 8'h41);
    step(0, 0); chk("ret2", bus.PM_ADDR, 8'h31);
    step(0, 0); chk("ret3", bus.PM_ADDR, 8'h21);
    step(0, 0); chk("ret4", bus.PM_ADDR, 8'h01);
    step(0, 0); chk("ret_empty_pc", bus.PM_ADDR, 8'h02);
    chk("ret_empty_err", bus.ERR, 1);

    // asynchronous reset in the middle of an LDI
    chk("mid_ldi_en_acc", bus.EN_ACC, 1);
    RST_N = 1'b0;
    model_reset();
    #1;
    chk("rst_en_acc", bus.EN_ACC, 0);
    chk("rst_pc", bus.PM_ADDR, 0);
    chk("rst_err", bus.ERR, 0);
    check_all();
    #2 RST_N = 1'b1;
    step(0, 0);
    chk("post_rst_boot_done", bus.PM_ADDR, 0);
    step(0, 0);
    chk("post_rst_fetch", bus.PM_ADDR, 8'h20);

    // HALT / START
    clear_pm();
    pm[8'h00] = ins(JMP, 8'h10);
    pm[8'h10] = ins(HLT, 0);
    pm[8'h11] = ins(LDI, 8'h22);
    do_reset();
    step(0, 1);
    step(0, 0);
    step(0, 0);
    chk("halted", bus.HALTED, 1);
    for (int i = 0; i < 10; i++) begin
      chk("halt_pm_addr", bus.PM_ADDR, 8'h11);
      chk("halt_enables", {bus.EN_ACC, bus.EN_D_MEM, bus.EN_REG_F}, 0);
      step(i % 2, 0);
    end
    step(0, 1);
    chk("resume_halted", bus.HALTED, 0);
    chk("resume_pm_addr", bus.PM_ADDR, 8'h11);
    chk("resume_en_acc", bus.EN_ACC, 1);
    chk("resume_imm", bus.IMM, 8'h22);

    // random programs against the model
    for (int i = 0; i < 256; i++)
      pm[i] = ins(int'($urandom_range(0, 31)), int'($urandom_range(0, 255)));
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      step(bit'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      if (c == 700) begin
        for (int i = 0; i < 256; i++)
          pm[i] = ins(int'($urandom_range(0, 31)), int'($urandom_range(0, 255)));
        do_reset();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cpu_ctrl.md
Name: cpu_ctrl

Overview:
- Single-cycle instruction sequencer for the 8-bit cpu_data datapath.
- Holds the program counter (PC), fetches one instruction per cycle from an asynchronous-read program memory, and decodes it into the datapath control signals.
- Handles JMP/JZ/JNZ on the datapath Z flag, a 4-deep CALL/RET return stack, and a HALT/START run-control state machine.

Parameters:
- WIDTH, 8, datapath/operand width.
- IWIDTH, 5, opcode width; instruction word is IWIDTH+WIDTH = 13 bits, {opcode, operand}.
- PC_WIDTH, 8, program counter / program memory address width.
- REG_F_SEL_SIZE, 4, register-file select width.
- IN_B_SEL_SIZE, 2, ALU B-input mux select width.
- STACK_DEPTH, 4, return stack entries (power of 2).

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  resume request; only honoured in HALT.
- PM_ADDR  out  PC_WIDTH  program memory address (= PC).
- PM_DATA  in  IWIDTH+WIDTH  instruction at PM_ADDR, same cycle (async read).
- Z  in  1  datapath zero flag.
- REG_F_SEL  out  REG_F_SEL_SIZE  register select = operand[3:0].
- EN_REG_F  out  1  register-file write enable.
- D_MEM_ADDR  out  WIDTH  data memory address = operand.
- D_MEM_ADDR_MODE  out  1  0 = address from operand, 1 = address from selected register.
- EN_D_MEM  out  1  data memory write enable.
- IN_B_SEL  out  IN_B_SEL_SIZE  00 IMM, 01 register, 10 data memory.
- IMM  out  WIDTH  immediate = operand.
- ALU_OUT  out  IWIDTH-1  ALU op; 4'hF = pass B.
- EN_ACC  out  1  accumulator load enable.
- HALTED  out  1  high in HALT state.
- ERR  out  1  sticky error flag.

Behaviour:

States and transitions:
- States: BOOT, RUN, HALT.
- Reset asserted → BOOT, PC=0, stack pointer SP=0, ERR=0.
- BOOT → RUN after exactly one cycle.
- RUN → HALT on a HALT instruction.
- HALT → RUN on a cycle with START=1; first fetch is at the held PC.

Output defaults (during reset, BOOT, HALT, and for NOP/reserved opcodes):
- All enables 0, IN_B_SEL=00, ALU_OUT=4'hF, D_MEM_ADDR_MODE=0.
- REG_F_SEL=0, D_MEM_ADDR=0, IMM=0.
- PM_ADDR always reflects PC.

Decode in RUN (combinational from PM_DATA, takes effect the same cycle; PC updates at the rising edge; default next PC = PC+1, wrapping 255→0):
- 00000 NOP.
- 00001 LDI: IMM=op, IN_B_SEL=00, ALU_OUT=F, EN_ACC=1.
- 00010 LD: D_MEM_ADDR=op, IN_B_SEL=10, ALU_OUT=F, EN_ACC=1.
- 00011 LDR: REG_F_SEL=op[3:0], IN_B_SEL=01, ALU_OUT=F, EN_ACC=1.
- 00100 ST: D_MEM_ADDR=op, mode 0, EN_D_MEM=1.
- 00101 STI: REG_F_SEL=op[3:0], mode 1, EN_D_MEM=1.
- 00110 STR: REG_F_SEL=op[3:0], EN_REG_F=1.
- 00111 JMP: PC ← op.
- 01000 JZ: PC ← op if Z=1, else PC+1.
- 01001 JNZ: PC ← op if Z=0, else PC+1.
- 01010 CALL: stack[SP] ← PC+1, SP+1, PC ← op.
- 01011 RET: SP−1, PC ← stack[SP−1].
- 01100 HALT: PC ← PC+1, go to HALT.
- 01101–01111 reserved: NOP behaviour and set ERR.
- 1oooo ALU op: ALU_OUT=oooo, IN_B_SEL=10, D_MEM_ADDR=op, EN_ACC=1.

Boundary conditions:
- Z is sampled combinationally in the branch cycle.
- CALL with stack full (SP=STACK_DEPTH): no push, no jump, PC+1, ERR set.
- RET with stack empty (SP=0): PC+1, ERR set.
- ERR is cleared only by reset.
- START in RUN or BOOT is ignored.
- Reset mid-instruction: all enables drop to 0 immediately (asynchronous); the write in flight is lost.
- No enable is ever asserted in BOOT or HALT.

Test Plan:
1. Reset release with PM[0]=LDI 0x69 → one BOOT cycle with EN_ACC=0, then a RUN cycle with EN_ACC=1, IMM=0x69, IN_B_SEL=00, ALU_OUT=F; PM_ADDR sequence 0,0,1.
2. PM[1]=ST 0x00 → EN_D_MEM=1, D_MEM_ADDR=0x00, mode 0. PM[2]=STR 3 → EN_REG_F=1, REG_F_SEL=3. PM[3]=ADD(10101) 0x00 → ALU_OUT=5, IN_B_SEL=10, EN_ACC=1.
3. JZ 0x40 with Z=1 → next PM_ADDR=0x40; with Z=0 → PM_ADDR+1. JNZ is the mirror; JMP 0xFF then NOP → PM_ADDR wraps to 0x00.
4. Five nested CALLs with no RET → first four jump; the fifth leaves PC+1 and sets ERR=1. Four RETs return in LIFO order; a fifth RET with the stack empty → PC+1, ERR stays 1.
5. HALT at 0x10 → HALTED=1, all enables 0, PM_ADDR=0x11 held over 10 cycles with START=0; START pulse → RUN, next fetch at 0x11.
6. RST_N low for 3 ns mid-LDI (between edges) → EN_ACC drops immediately, PC=0, ERR=0, one BOOT cycle before fetch resumes.
